// File: rtl/nanolada_pkg.sv
// Shared nanoLADA definitions: I/O window layout, STATUS bit positions and
// the address decode used by the data-memory responder.
package nanolada_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [31:0] CYCLE_OFFSET  = 32'h0000_0000;
    localparam logic [31:0] TXDATA_OFFSET = 32'h0000_0004;
    localparam logic [31:0] STATUS_OFFSET = 32'h0000_0008;

    localparam int STATUS_OVERFLOW_BIT = 10;
    localparam int STATUS_FULL_BIT     = 9;
    localparam int STATUS_EMPTY_BIT    = 8;
    localparam int STATUS_COUNT_W      = 5;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_CYCLE,
        REGION_TXDATA,
        REGION_STATUS,
        REGION_NONE
    } region_t;

    // Byte offsets are dropped first; RAM takes precedence over the window.
    function automatic region_t decode_region(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned addr_width);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if ((word_addr >> (addr_width + 2)) == 32'd0)
            return REGION_RAM;
        else if (word_addr == base + CYCLE_OFFSET)
            return REGION_CYCLE;
        else if (word_addr == base + TXDATA_OFFSET)
            return REGION_TXDATA;
        else if (word_addr == base + STATUS_OFFSET)
            return REGION_STATUS;
        else
            return REGION_NONE;
    endfunction

    function automatic logic [31:0] pack_status(input logic overflow,
                                                input logic full,
                                                input logic empty,
                                                input logic [STATUS_COUNT_W-1:0] count);
        logic [31:0] status;
        status = '0;
        status[STATUS_OVERFLOW_BIT]    = overflow;
        status[STATUS_FULL_BIT]        = full;
        status[STATUS_EMPTY_BIT]       = empty;
        status[STATUS_COUNT_W-1:0]     = count;
        return status;
    endfunction

endpackage

// File: rtl/nanomem_if.sv
// CPU data-port control lines and the TX byte stream toward the external sink.
interface nanomem_if;
    logic [31:0] data_address;
    logic        mem_write;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output data_address,
        output mem_write,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  data_address,
        input  mem_write,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/nano_fifo.sv
// Small synchronous FIFO with a combinational head; a push into a full FIFO
// only succeeds when a pop frees the head slot on the same edge.
module nano_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             not_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             drop
);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = slots[rd_ptr];
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                slots[i] <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nanomem.sv
// Data-memory responder for the nanoCPU: word RAM plus an I/O window holding
// a free-running cycle counter and a byte TX FIFO drained by valid/ready.
module nanomem
    import nanolada_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic      clock,
    input  logic      not_reset,
    nanomem_if.slave  bus,
    inout  wire [31:0] data_data
);

    localparam int FIFO_COUNT_W = $clog2(FIFO_DEPTH + 1);

    region_t                 region;
    logic [31:0]             ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0]   ram_index;
    logic [31:0]             cycle_count;
    logic                    overflow;
    logic [31:0]             read_data;

    logic                    push_tx;
    logic                    pop_tx;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_drop;
    logic [FIFO_COUNT_W-1:0] fifo_count;
    logic [7:0]              fifo_head;

    assign region    = decode_region(bus.data_address, MMIO_BASE, ADDR_WIDTH);
    assign ram_index = bus.data_address[ADDR_WIDTH+1:2];
    assign push_tx   = bus.mem_write && (region == REGION_TXDATA);
    assign pop_tx    = !fifo_empty && bus.tx_ready;

    assign bus.tx_data  = fifo_head;
    assign bus.tx_valid = !fifo_empty;

    // RAM keeps its contents across reset, so it sits outside the reset domain.
    always_ff @(posedge clock) begin
        if (bus.mem_write && region == REGION_RAM)
            ram[ram_index] <= data_data;
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset)
            cycle_count <= '0;
        else if (bus.mem_write && region == REGION_CYCLE)
            cycle_count <= data_data;
        else
            cycle_count <= cycle_count + 32'd1;
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset)
            overflow <= 1'b0;
        else if (fifo_drop)
            overflow <= 1'b1;
        else if (bus.mem_write && region == REGION_STATUS)
            overflow <= 1'b0;
    end

    nano_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .not_reset (not_reset),
        .push      (push_tx),
        .push_data (data_data[7:0]),
        .pop       (pop_tx),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    always_comb begin
        read_data = '0;
        case (region)
            REGION_RAM:    read_data = ram[ram_index];
            REGION_CYCLE:  read_data = cycle_count;
            REGION_STATUS: read_data = pack_status(overflow, fifo_full, fifo_empty,
                                                   STATUS_COUNT_W'(fifo_count));
            default:       read_data = '0;
        endcase
    end

    // The CPU owns the bus during writes; we only drive it for reads.
    assign data_data = bus.mem_write ? 32'bz : read_data;

endmodule

// File: tb/tb_nanomem.sv
// Directed bench for nanomem: a vector table for decode/RAM behaviour plus
// hand-written sequences for the counter, TX FIFO corners and reset.
module tb_nanomem;

    localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_0000;
    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0008;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expect_data;
        string       name;
    } vec_t;

    logic        clock;
    logic        not_reset;
    logic        tb_drive;
    logic [31:0] tb_wdata;
    wire  [31:0] data_data;

    int checks;
    int errors;

    vec_t vecs[$];

    nanomem_if bus ();

    assign data_data = tb_drive ? tb_wdata : 32'bz;

    nanomem #(
        .ADDR_WIDTH (10),
        .FIFO_DEPTH (4),
        .MMIO_BASE  (32'hFFFF_0000)
    ) dut (
        .clock     (clock),
        .not_reset (not_reset),
        .bus       (bus),
        .data_data (data_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Write occupies one rising edge; returns 1 time unit after that edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_address = addr;
        tb_wdata         = wdata;
        tb_drive         = 1'b1;
        bus.mem_write    = 1'b1;
        @(posedge clock);
        #1;
        bus.mem_write    = 1'b0;
        tb_drive         = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] expected,
                            input string name);
        bus.data_address = addr;
        bus.mem_write    = 1'b0;
        tb_drive         = 1'b0;
        #1;
        check_output(name, data_data, expected);
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.wr)
            bus_write(v.addr, v.wdata);
        else
            bus_read(v.addr, v.expect_data, v.name);
    endtask

    initial begin
        logic [7:0] drain_exp [4];

        checks           = 0;
        errors           = 0;
        not_reset        = 1'b0;
        tb_drive         = 1'b0;
        tb_wdata         = '0;
        bus.data_address = '0;
        bus.mem_write    = 1'b0;
        bus.tx_ready     = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        check_output("reset_tx_data", 32'(bus.tx_data), 32'h0);
        bus_read(CYCLE_ADDR, 32'h0, "reset_cycle");

        // Cycle counter: five edges after release, then load and wrap
        @(posedge clock);
        #1;
        not_reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        bus_read(CYCLE_ADDR, 32'd5, "cycle_after_5");
        bus_write(CYCLE_ADDR, 32'hFFFF_FFFE);
        bus_read(CYCLE_ADDR, 32'hFFFF_FFFE, "cycle_loaded");
        repeat (3) @(posedge clock);
        #1;
        bus_read(CYCLE_ADDR, 32'h0000_0001, "cycle_wrap");

        // Decode / RAM vector table
        vecs.push_back('{1'b0, STATUS_ADDR,   32'h0,         32'h0000_0100, "status_idle"});
        vecs.push_back('{1'b0, TXDATA_ADDR,   32'h0,         32'h0,         "txdata_read"});
        vecs.push_back('{1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0,         "wr_14"});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         "wr_10"});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, "ram_13"});
        vecs.push_back('{1'b0, 32'h0000_0011, 32'h0,         32'hDEAD_BEEF, "ram_11"});
        vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, "ram_14"});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,         "wr_00"});
        vecs.push_back('{1'b1, 32'h0000_1000, 32'hFFFF_1111, 32'h0,         "wr_1000"});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, "ram_no_alias"});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         32'h0,         "above_ram"});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 32'hA5A5_0001, 32'h0,         "wr_top"});
        vecs.push_back('{1'b0, 32'h0000_0FFE, 32'h0,         32'hA5A5_0001, "ram_top"});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         32'h0,         "unmapped_hi"});
        vecs.push_back('{1'b0, 32'hFFFF_000C, 32'h0,         32'h0,         "mmio_gap"});
        foreach (vecs[i])
            apply_stimulus(vecs[i]);

        // Fill past full with the sink stalled, then drain
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            bus_write(TXDATA_ADDR, 32'h41 + 32'(i));
        bus_read(STATUS_ADDR, 32'h0000_0604, "status_full_ovf");
        check_output("full_tx_valid", 32'(bus.tx_valid), 32'h1);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_output("drain_byte", 32'(bus.tx_data), 32'h41 + 32'(i));
            @(posedge clock);
            #1;
        end
        check_output("drained_tx_valid", 32'(bus.tx_valid), 32'h0);
        bus.tx_ready = 1'b0;
        bus_read(STATUS_ADDR, 32'h0000_0500, "status_empty_ovf");
        bus_write(STATUS_ADDR, 32'hFFFF_FFFF);
        bus_read(STATUS_ADDR, 32'h0000_0100, "status_ovf_clear");

        // Push into empty FIFO while the sink is ready: nothing to pop yet
        bus.tx_ready = 1'b1;
        bus_write(TXDATA_ADDR, 32'h66);
        check_output("empty_push_valid", 32'(bus.tx_valid), 32'h1);
        check_output("empty_push_data", 32'(bus.tx_data), 32'h66);
        bus_read(STATUS_ADDR, 32'h0000_0001, "empty_push_status");
        @(posedge clock);
        #1;
        check_output("empty_push_popped", 32'(bus.tx_valid), 32'h0);

        // Full FIFO with simultaneous push and pop
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            bus_write(TXDATA_ADDR, 32'h51 + 32'(i));
        bus.tx_ready = 1'b1;
        bus_write(TXDATA_ADDR, 32'h55);
        bus_read(STATUS_ADDR, 32'h0000_0204, "full_push_pop_status");
        drain_exp = '{8'h52, 8'h53, 8'h54, 8'h55};
        for (int i = 0; i < 4; i++) begin
            check_output("push_pop_order", 32'(bus.tx_data), 32'(drain_exp[i]));
            @(posedge clock);
            #1;
        end
        check_output("push_pop_empty", 32'(bus.tx_valid), 32'h0);
        bus.tx_ready = 1'b0;

        // Reset asserted between edges in the middle of a drain
        bus_write(32'h0000_0020, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++)
            bus_write(TXDATA_ADDR, 32'h71 + 32'(i));
        bus.tx_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_output("mid_drain_head", 32'(bus.tx_data), 32'h73);
        bus.tx_ready = 1'b0;
        #2;
        not_reset = 1'b0;
        #1;
        check_output("async_rst_valid", 32'(bus.tx_valid), 32'h0);
        check_output("async_rst_data", 32'(bus.tx_data), 32'h0);
        bus_read(STATUS_ADDR, 32'h0000_0100, "async_rst_status");
        bus_read(CYCLE_ADDR, 32'h0, "async_rst_cycle");
        @(posedge clock);
        #1;
        not_reset = 1'b1;
        bus_read(32'h0000_0020, 32'hCAFE_F00D, "ram_survives_reset");

        // During a write only the CPU side may drive the bus
        bus.data_address = 32'h0000_0020;
        tb_wdata         = 32'h1357_9BDF;
        tb_drive         = 1'b1;
        bus.mem_write    = 1'b1;
        #1;
        check_output("no_contention", data_data, 32'h1357_9BDF);
        @(posedge clock);
        #1;
        bus.mem_write = 1'b0;
        tb_drive      = 1'b0;
        bus_read(32'h0000_0020, 32'h1357_9BDF, "ram_overwrite");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
